// File: rtl/dispatch_4_pkg.sv
// Shared constants for the 1-to-4 dispatcher: channel encodings and default payload width.
package dispatch_4_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned NumChannels  = 4;

  typedef enum logic [1:0] {
    CH0 = 2'd0,
    CH1 = 2'd1,
    CH2 = 2'd2,
    CH3 = 2'd3
  } channel_e;

  function automatic logic [NumChannels-1:0] channel_onehot(input channel_e ch);
    logic [NumChannels-1:0] oh;
    oh = '0;
    unique case (ch)
      CH0: oh = 4'b0001;
      CH1: oh = 4'b0010;
      CH2: oh = 4'b0100;
      CH3: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dispatch_4_slot.sv
// One dispatcher channel: a valid bit and a payload register with load and drain.
module dispatch_4_slot
  import dispatch_4_pkg::*;
#(
  parameter int unsigned width = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data
);

  logic             valid_q;
  logic [width-1:0] data_q;

  // A load on the same edge as a drain keeps the slot full with the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= load_data;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/dispatch_4.sv
// Registered 1-to-4 dispatcher: routes each accepted word into the holding slot chosen by in_sel.
module dispatch_4
  import dispatch_4_pkg::*;
#(
  parameter int unsigned width = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [width-1:0] out_data0,
  output logic [width-1:0] out_data1,
  output logic [width-1:0] out_data2,
  output logic [width-1:0] out_data3,
  output logic             busy
);

  logic [3:0]       load;
  logic [width-1:0] slot_data [4];
  logic             accept;

  // Only the targeted slot gates in_ready; other channels never stall the source.
  assign in_ready = ~reset & (~out_valid[in_sel] | out_ready[in_sel]);
  assign accept   = in_valid & in_ready;
  assign load     = accept ? channel_onehot(channel_e'(in_sel)) : 4'b0000;

  for (genvar k = 0; k < 4; k++) begin : g_slot
    dispatch_4_slot #(
      .width(width)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (load[k]),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (slot_data[k])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign busy      = |out_valid;

endmodule
